// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable sequence detector.
// The reset defaults make the block behave like the legacy fixed "001" detector.
package seq_det_pkg;

    localparam int RST_PAT = 1;
    localparam int RST_LEN = 3;
    localparam bit RST_OVL = 1'b1;

    // Width needed to hold a length value from 0 to max_len inclusive.
    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating event counter with synchronous clear.
// A clear arriving together with an increment leaves the count at 1.
module seq_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with optional overlap, Mealy or Moore
// output timing and a saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int  MAX_LEN = 8,
    parameter int  CNT_W   = 16,
    parameter bit  MEALY   = 1'b1,
    localparam int LW      = calc_lw(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               inp_vld,
    input  logic               cfg_ld,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;
    logic               det_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_ok;
    logic               len_ok;
    logic               pat_eq;
    logic               hit;

    assign cfg_ok = cfg_ld && (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

    // The candidate window is the stored history with the current bit appended;
    // only its low len bits take part in the compare.
    assign window = {hist, inp};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign len_ok = (fill >= (len - LW'(1)));
    assign pat_eq = (((window ^ pat) & mask) == '0);
    assign hit    = rst && inp_vld && !cfg_ok && len_ok && pat_eq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat   <= MAX_LEN'(RST_PAT);
            len   <= LW'(RST_LEN);
            ovl   <= RST_OVL;
            hist  <= '0;
            fill  <= '0;
            det_q <= 1'b0;
        end else begin
            det_q <= hit;
            if (cfg_ok) begin
                pat  <= cfg_pat;
                len  <= cfg_len;
                ovl  <= cfg_ovl;
                hist <= '0;
                fill <= '0;
            end else if (inp_vld) begin
                hist <= window[MAX_LEN-2:0];
                // Non-overlapping mode forgets the bits that formed the match.
                if (hit && !ovl) begin
                    fill <= '0;
                end else if (fill != LW'(MAX_LEN)) begin
                    fill <= fill + LW'(1);
                end
            end
        end
    end

    assign det = MEALY ? hit : det_q;

    seq_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule
